page_sweep_ctl: RTL
===================

# page_sweep_ctl

Hardware sequencer and write-port arbiter for the KS-10 page table. On a microcode sweep request it invalidates all 256 even/odd entry pairs, one pair per enabled clock, by zero-writing them. Microcode page writes share the table write port with the sweep. Lookups of entries the sweep has not reached yet are reported invalid. The block sits between microcode decode and the page table write/read ports inside the CPU.

## Interface
Parameters:
- PAIRS, 256, number of entry pairs; must be a power of two.
- PW, 8, pair-pointer width; equals log2(PAIRS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clken  in  1  CPU clock enable; all state advances only when high.
- sweepREQ  in  1  start/restart full sweep (microcode CLRCACHE decode).
- cpuWR  in  1  microcode page-write request.
- cpuWADDR  in  9  virtual page number of the write (VMA[18:26]); bits [1:8] are the pair index.
- cpuRADDR  in  9  virtual page number of the lookup (DP[18:26]).
- tblWE  out  1  table write enable.
- tblADDR  out  8  table pair address.
- tblCLR  out  1  write zeros to both halves of the pair; when low, only half cpuWADDR[0] is written with CPU data.
- cpuSTALL  out  1  CPU write not accepted this cycle; microcode holds cpuWR and cpuWADDR.
- lkINVALID  out  1  force the page-valid bit of the current lookup to 0.
- sweepBUSY  out  1  sweep in progress.
- sweepDONE  out  1  one-cycle completion pulse.

## Operation
- State: IDLE, SWEEP, DONE. Pointer ptr is PW bits. All outputs reset to 0, state resets to IDLE, ptr resets to 0.
- IDLE:
  - sweepREQ with clken: ptr←0, go to SWEEP.
  - cpuWR is always granted: tblWE=1, tblCLR=0, tblADDR=cpuWADDR[1:8].
- SWEEP: the sweepBUSY output is 1. Each cycle, arbitrate as follows.
  - cpuWR and pair(cpuWADDR) < ptr (entry already cleared): grant the CPU write. ptr holds, and the sweep yields that cycle.
  - cpuWR and pair ≥ ptr: cpuSTALL=1. Issue the sweep clear of ptr (tblWE=1, tblCLR=1, tblADDR=ptr). This prevents a later clear from destroying new data.
  - No cpuWR: issue the sweep clear of ptr.
  - After each issued clear, with clken: ptr←ptr+1. A clear at ptr=PAIRS-1 goes to DONE, and ptr wraps to 0.
- DONE: sweepDONE=1 for one clken cycle, then IDLE. cpuWR is granted as in IDLE.
- lkINVALID = sweepBUSY & (pair(cpuRADDR) ≥ ptr). It is combinational. It is 0 in IDLE and DONE.
- sweepREQ in SWEEP restarts the sweep: ptr←0, stay in SWEEP. The clear issued that cycle still completes.
- sweepREQ in DONE: enter SWEEP with ptr=0. No sweepDONE is emitted for that cycle.
- Stall bound: a stalled CPU write to pair p is granted on the first clken cycle after ptr exceeds p. The bound is therefore ≤ PAIRS clken cycles.

## Timing
- All control outputs are combinational from registered state/ptr and current inputs. The table samples them at the clk edge where clken=1.
- clken=0: no state or ptr change. Outputs may toggle, but the table ignores them.
- sweepREQ → sweepBUSY=1 at the next clken edge. An uncontended sweep takes exactly PAIRS clken cycles in SWEEP. Each granted CPU write adds one cycle.
- sweepDONE asserts the cycle after the last clear and sweepBUSY deasserts in that same cycle.
- rst mid-sweep: immediately IDLE with ptr=0. Remaining entries are not cleared, and no sweepDONE is emitted.

## Structure
- Shared package (pager_pkg): state enum {IDLE, SWEEP, DONE}, PAIRS/PW constants, and a pair-index extraction function shared with the pager.
- Single module, no sub-modules. The arbiter compare (pair vs. ptr) is inline.

## Test plan
- Uncontended sweep: pulse sweepREQ with clken always 1 → exactly 256 tblWE/tblCLR writes at addresses 0..255 in order; sweepDONE 257 cycles after the request edge.
- CPU write behind pointer: at ptr=10, cpuWR with cpuWADDR=0x00A (pair 5) → granted, tblADDR=5, tblCLR=0, cpuSTALL=0; ptr stays 10 for that cycle.
- CPU write ahead of pointer: at ptr=10, cpuWR pair 200 held → cpuSTALL=1 through ptr=200; granted on the cycle with ptr=201; sweep finishes one cycle late.
- Lookup masking: at ptr=50, cpuRADDR pair 49 → lkINVALID=0; pair 50 → lkINVALID=1; in IDLE, any address → lkINVALID=0.
- Restart and clken gating: sweepREQ at ptr=100 → next clear at address 0 and 256 more clears; clken low for 5 cycles mid-sweep → ptr frozen, no duplicate or missed addresses.
- Reset mid-sweep: rst at ptr=30 → sweepBUSY=0, sweepDONE never pulses, next sweep starts at 0.

Source files
------------

// File: rtl/pager_pkg.sv
// Shared pager definitions: sweep sequencer states, table geometry and the
// pair-index extraction used by both the sweep controller and the pager.
package pager_pkg;

   localparam int PG_PAIRS = 256;
   localparam int PG_PW    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_e;

   // VMA[18:26]: bit 0 selects the half, bits [8:1] select the pair
   function automatic logic [PG_PW-1:0] pair_of(input logic [8:0] vpn);
      return vpn[8:1];
   endfunction

endpackage

// File: rtl/page_sweep_ctl.sv
// Page-table sweep sequencer and write-port arbiter: zero-writes every entry
// pair on CLRCACHE while letting microcode writes behind the pointer through.
module page_sweep_ctl
   import pager_pkg::*;
#(
   parameter int PAIRS = PG_PAIRS,
   parameter int PW    = PG_PW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clken,
   input  logic          sweepREQ,
   input  logic          cpuWR,
   input  logic [8:0]    cpuWADDR,
   input  logic [8:0]    cpuRADDR,
   output logic          tblWE,
   output logic [PW-1:0] tblADDR,
   output logic          tblCLR,
   output logic          cpuSTALL,
   output logic          lkINVALID,
   output logic          sweepBUSY,
   output logic          sweepDONE
);

   sweep_state_e  r_state;
   sweep_state_e  w_state_nx;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_ptr_nx;
   logic [PW-1:0] w_wpair;
   logic [PW-1:0] w_rpair;
   logic          w_behind;
   logic          w_clear;
   logic          w_last;

   assign w_wpair  = pair_of(cpuWADDR);
   assign w_rpair  = pair_of(cpuRADDR);
   assign w_behind = cpuWR & (w_wpair < r_ptr);
   assign w_clear  = (r_state == ST_SWEEP) & ~w_behind;
   assign w_last   = (r_ptr == PW'(PAIRS - 1));

   // Write-port arbitration and status outputs, held quiet while in reset
   always_comb begin
      tblWE     = 1'b0;
      tblADDR   = w_wpair;
      tblCLR    = 1'b0;
      cpuSTALL  = 1'b0;
      lkINVALID = 1'b0;
      sweepBUSY = 1'b0;
      sweepDONE = 1'b0;
      if (rst) begin
         tblADDR = {PW{1'b0}};
      end else begin
         case (r_state)
            ST_SWEEP: begin
               sweepBUSY = 1'b1;
               lkINVALID = (w_rpair >= r_ptr);
               tblWE     = 1'b1;
               if (w_behind) begin
                  tblCLR = 1'b0;
               end else begin
                  // a write at or ahead of the pointer would be wiped later
                  tblCLR   = 1'b1;
                  tblADDR  = r_ptr;
                  cpuSTALL = cpuWR;
               end
            end
            ST_DONE: begin
               tblWE     = cpuWR;
               sweepDONE = ~sweepREQ;
            end
            default: begin
               tblWE = cpuWR;
            end
         endcase
      end
   end

   // Next state and pointer; a sweep request always restarts from pair 0
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (sweepREQ) begin
               w_state_nx = ST_SWEEP;
               w_ptr_nx   = {PW{1'b0}};
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            if (sweepREQ) begin
               w_ptr_nx = {PW{1'b0}};
            end else if (w_clear && w_last) begin
               w_state_nx = ST_DONE;
               w_ptr_nx   = {PW{1'b0}};
            end else if (w_clear) begin
               w_ptr_nx = r_ptr + {{(PW-1){1'b0}}, 1'b1};
            end else begin
               w_ptr_nx = r_ptr;
            end
         end
         ST_DONE: begin
            if (sweepREQ) begin
               w_state_nx = ST_SWEEP;
               w_ptr_nx   = {PW{1'b0}};
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_ptr_nx   = {PW{1'b0}};
         end
      endcase
   end

   // State registers advance only on enabled CPU clocks
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= {PW{1'b0}};
      end else if (clken) begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
      end else begin
         r_state <= r_state;
         r_ptr   <= r_ptr;
      end
   end

endmodule
